// File: rtl/upsp_wr_sequencer.sv
// ---------------------------------------------------------------------------
// upsp_wr_sequencer
//
// Merges the result pixels of N_PARALLEL upsampler write lanes into one
// AXI4-Stream in raster order. Each lane owns QUANTUM-pixel-wide column
// strips. The grant moves lane 0, 1, ... N_PARALLEL-1, then wraps, and
// holds for QUANTUM accepted beats. Every row restarts at lane 0. The
// granted lane is never skipped, so a stalled lane stalls the whole stream.
//
// The block builds tuser (first pixel of the frame) and tlast (last pixel of
// a row) and pulses frame_done when the downstream side accepts the last
// beat of the frame.
//
// Ports
//   clk, rst          sole clock; asynchronous active-high reset
//   start             one-cycle pulse, arms one frame (honoured in IDLE only)
//   abort             synchronous soft clear back to IDLE (wins over start
//                     and over lane transfers)
//   upsp_wvalid/wdata per-lane write side; lane i data at [i*W +: W]
//   upsp_wready       per-lane ready, at most one bit high
//   m_axis_*          output stream; tid is the lane that sourced the beat
//   busy              high in RUN and DRAIN
//   frame_done        one-cycle pulse on acceptance of the frame's last beat
//   cur_lane          currently granted lane
// ---------------------------------------------------------------------------
module upsp_wr_sequencer #(
  parameter int N_PARALLEL         = 4,
  parameter int UPSP_WRTDATA_WIDTH = 24,
  parameter int DST_IMG_WIDTH      = 3840,
  parameter int DST_IMG_HEIGHT     = 2160,
  parameter int QUANTUM            = 4,
  localparam int LANE_W = (N_PARALLEL > 1) ? $clog2(N_PARALLEL) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic [N_PARALLEL-1:0]                    upsp_wvalid,
  input  logic [N_PARALLEL*UPSP_WRTDATA_WIDTH-1:0] upsp_wdata,
  output logic [N_PARALLEL-1:0]                    upsp_wready,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  output logic [UPSP_WRTDATA_WIDTH-1:0]            m_axis_tdata,
  output logic                                     m_axis_tlast,
  output logic                                     m_axis_tuser,
  output logic [LANE_W-1:0]                        m_axis_tid,
  output logic                                     busy,
  output logic                                     frame_done,
  output logic [LANE_W-1:0]                        cur_lane
);

  localparam int BEAT_W = (QUANTUM > 1)        ? $clog2(QUANTUM)        : 1;
  localparam int COL_W  = (DST_IMG_WIDTH > 1)  ? $clog2(DST_IMG_WIDTH)  : 1;
  localparam int ROW_W  = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;

  localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(QUANTUM - 1);
  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(DST_IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(DST_IMG_HEIGHT - 1);
  localparam logic [LANE_W-1:0]     LANE_LAST = LANE_W'(N_PARALLEL - 1);
  localparam logic [N_PARALLEL-1:0] LANE_ONE  = N_PARALLEL'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [BEAT_W-1:0]             beat_cnt;
  logic [COL_W-1:0]              col_cnt;
  logic [ROW_W-1:0]              row_cnt;
  logic [UPSP_WRTDATA_WIDTH-1:0] lane_data;

  logic load_ok, grant_ok, lane_xfer, out_xfer;
  logic last_beat, last_col, last_row, frame_last;

  // The single output register may take a new beat when it is empty or is
  // being emptied in this same cycle, which gives full throughput.
  assign load_ok  = !m_axis_tvalid || m_axis_tready;
  assign out_xfer = m_axis_tvalid && m_axis_tready;

  // abort masks the grant so a lane never sees a handshake that the
  // sequencer then throws away.
  assign grant_ok    = (state_q == ST_RUN) && load_ok && !abort;
  assign upsp_wready = grant_ok ? (LANE_ONE << cur_lane) : '0;
  assign lane_xfer   = grant_ok && upsp_wvalid[cur_lane];
  assign lane_data   = upsp_wdata[cur_lane*UPSP_WRTDATA_WIDTH +: UPSP_WRTDATA_WIDTH];

  assign last_beat  = (beat_cnt == BEAT_LAST);
  assign last_col   = (col_cnt == COL_LAST);
  assign last_row   = (row_cnt == ROW_LAST);
  assign frame_last = last_col && last_row;

  // NOTE: every signal written here gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (lane_xfer && frame_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Only the frame's final beat can sit in the register here.
        if (out_xfer) begin
          frame_done = !abort;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Counters, grant pointer and the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt      <= '0;
      col_cnt       <= '0;
      row_cnt       <= '0;
      cur_lane      <= '0;
      m_axis_tvalid <= 1'b0;
      // NOTE: the payload fields are datapath that tvalid qualifies, but
      // they are outputs that must read 0 out of reset, so they are reset too.
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tid    <= '0;
    end else if (abort) begin
      beat_cnt      <= '0;
      col_cnt       <= '0;
      row_cnt       <= '0;
      cur_lane      <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (lane_xfer) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= lane_data;
        m_axis_tid    <= cur_lane;
        m_axis_tlast  <= last_col;
        m_axis_tuser  <= (col_cnt == '0) && (row_cnt == '0);

        // Row width is a multiple of QUANTUM, so beat_cnt wraps together
        // with col_cnt at the end of every row.
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        if (last_col) begin
          col_cnt  <= '0;
          row_cnt  <= last_row ? '0 : row_cnt + 1'b1;
          cur_lane <= '0;
        end else begin
          col_cnt <= col_cnt + 1'b1;
          if (last_beat) cur_lane <= (cur_lane == LANE_LAST) ? '0 : cur_lane + 1'b1;
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      // Arming a frame starts from a clean raster position. No lane
      // transfer can happen in IDLE, so this never competes with the above.
      if (state_q == ST_IDLE && start) begin
        beat_cnt <= '0;
        col_cnt  <= '0;
        row_cnt  <= '0;
        cur_lane <= '0;
      end
    end
  end

endmodule
